key_expand: RTL and testbench

KEY_EXPAND -- requirements
Module: key_expand

---
 rtl/key_expand_if.sv | 18 +
 rtl/key_expand.sv | 139 +++++++++++++
 tb/tb_key_expand.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/key_expand_if.sv
// key_expand_if -- request/read bus of the AES-128 key expander.
//   key       : 128-bit cipher key (byte 0 at [127:120])
//   start     : one-cycle expansion request
//   round_idx : round-key read index 0..10 (11..15 read as zero)
//   round_key : registered round key for round_idx
//   busy      : expansion in progress
//   key_valid : all 11 round keys belong to the last accepted key
interface key_expand_if;
  logic [127:0] key;
  logic         start;
  logic [3:0]   round_idx;
  logic [127:0] round_key;
  logic         busy;
  logic         key_valid;

  modport master (output key, start, round_idx, input round_key, busy, key_valid);
  modport slave  (input key, start, round_idx, output round_key, busy, key_valid);
endinterface

// File: rtl/key_expand.sv
// aes_sbox   -- 8-bit AES S-box: GF(2^8) inverse followed by the affine map.
//   i_byte : input byte
//   o_byte : substituted byte
// key_expand -- AES-128 key schedule, one word per cycle, 11 round keys kept
//   in storage and read back through a registered port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : key_expand_if.slave (key/start/round_idx in, round_key/busy/key_valid out)
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8), and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  logic [7:0] w_inv;

  always_comb begin
    w_inv  = ginv(i_byte);
    o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
           ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
  end
endmodule

module key_expand (
  input  logic       clk,
  input  logic       rst_n,
  key_expand_if.slave bus
);
  typedef enum logic {IDLE, EXPAND} state_t;

  state_t              r_state, w_state_nxt;
  logic [5:0]          r_i;
  logic [3:0][31:0]    r_win;       // [0] = w[i-4] ... [3] = w[i-1]
  logic [10:0][127:0]  r_rk;
  logic [127:0]        r_round_key;
  logic                r_key_valid;

  logic [31:0] w_rot, w_sub, w_temp, w_new;
  logic [7:0]  w_rcon;

  // RotWord: most significant byte wraps to the bottom.
  assign w_rot = {r_win[3][23:0], r_win[3][31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (.i_byte(w_rot[g*8 +: 8]), .o_byte(w_sub[g*8 +: 8]));
  end

  always_comb begin
    case (r_i[5:2])
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  assign w_temp = (r_i[1:0] == 2'd0) ? (w_sub ^ {w_rcon, 24'h0}) : r_win[3];
  assign w_new  = r_win[0] ^ w_temp;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start)    w_state_nxt = EXPAND;
      EXPAND:  if (r_i == 6'd43) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i         <= 6'd4;
      r_win       <= '0;
      r_rk        <= '0;
      r_key_valid <= 1'b0;
    end else if (r_state == IDLE) begin
      if (bus.start) begin
        r_rk[0]     <= bus.key;
        r_win       <= {bus.key[31:0], bus.key[63:32], bus.key[95:64], bus.key[127:96]};
        r_i         <= 6'd4;
        r_key_valid <= 1'b0;
      end
    end else begin
      // Word i lands in round i/4, slot i%4 counted from the MSB end.
      r_rk[r_i[5:2]][{~r_i[1:0], 5'b0} +: 32] <= w_new;
      r_win <= {w_new, r_win[3], r_win[2], r_win[1]};
      if (r_i == 6'd43) begin
        r_i         <= 6'd4;
        r_key_valid <= 1'b1;
      end else begin
        r_i <= r_i + 6'd1;
      end
    end
  end

  // Registered read; same-edge writes are not visible until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_round_key <= '0;
    else if (bus.round_idx <= 4'd10) r_round_key <= r_rk[bus.round_idx];
    else                           r_round_key <= '0;
  end

  assign bus.round_key = r_round_key;
  assign bus.busy      = (r_state == EXPAND);
  assign bus.key_valid = r_key_valid;
endmodule

// File: tb/tb_key_expand.sv
module tb_key_expand;
  logic clk = 1'b0;
  logic rst_n;
  key_expand_if bus ();

  key_expand dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  sbox [256];
  logic [7:0]  rcon [11];
  logic [31:0] mw   [44];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // S-box built from the generator-3 walk over GF(2^8).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
    rcon[0] = 8'h00;
    rcon[1] = 8'h01;
    for (int r = 2; r <= 10; r++)
      rcon[r] = {rcon[r-1][6:0], 1'b0} ^ (rcon[r-1][7] ? 8'h1b : 8'h00);
  endtask

  task automatic model(input logic [127:0] k);
    logic [31:0] t;
    for (int j = 0; j < 4; j++) mw[j] = k[127 - 32*j -: 32];
    for (int j = 4; j < 44; j++) begin
      t = mw[j-1];
      if (j % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t = t ^ {rcon[j/4], 24'h0};
      end
      mw[j] = mw[j-4] ^ t;
    end
  endtask

  function automatic logic [127:0] exp_rk(input int r);
    if (r > 10) return '0;
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  task automatic read_rk(input int idx, output logic [127:0] v);
    bus.round_idx = idx[3:0];
    @(negedge clk);
    v = bus.round_key;
  endtask

  // Starts an expansion at the next posedge; optional second start pulse at
  // busy-cycle dup_at (must be ignored). Checks busy width and key_valid.
  task automatic run(input string tag, input logic [127:0] k, input int dup_at,
                     input logic [127:0] dk);
    int bc;
    bus.key = k; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_kv_drop"}, {127'b0, bus.key_valid}, 128'd0);
    bc = 0;
    for (int c = 0; c < 60; c++) begin
      if (bus.key_valid) break;
      if (bus.busy) bc++;
      if (c == dup_at) begin bus.key = dk; bus.start = 1'b1; end
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk({tag, "_busy_w"}, 128'(bc), 128'd40);
    chk({tag, "_kv"}, {126'b0, bus.busy, bus.key_valid}, 128'd1);
  endtask

  task automatic check_all(input string tag);
    logic [127:0] v;
    for (int r = 0; r < 16; r++) begin
      read_rk(r, v);
      chk($sformatf("%s_r%0d", tag, r), v, exp_rk(r));
    end
  endtask

  logic [127:0] v, k1, k2;

  initial begin
    build_sbox();
    rst_n = 1'b0; bus.key = '0; bus.start = 1'b0; bus.round_idx = '0;
    #12;
    chk("rst_busy", {127'b0, bus.busy}, 128'd0);
    chk("rst_kv", {127'b0, bus.key_valid}, 128'd0);
    chk("rst_rk", bus.round_key, 128'd0);

    // FIPS-197 vector, start on the first edge after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    k1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model(k1);
    run("fips", k1, -1, '0);
    read_rk(1, v);  chk("fips_r1", v, 128'ha0fafe1788542cb123a339392a6c7605);
    read_rk(10, v); chk("fips_r10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Latency sweep: output still shows previous index until the next edge.
    read_rk(0, v); chk("sweep_r0", v, k1);
    bus.round_idx = 4'd5;
    #1 chk("sweep_lat", bus.round_key, k1);
    check_all("fips");

    // All-zero key.
    model('0);
    run("zero", '0, -1, '0);
    read_rk(1, v);  chk("zero_r1", v, 128'h62636363626363636263636362636363);
    read_rk(10, v); chk("zero_r10", v, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Random keys, restarting while key_valid=1 each time.
    for (int t = 0; t < 4; t++) begin
      k2 = {$urandom, $urandom, $urandom, $urandom};
      model(k2);
      run($sformatf("rnd%0d", t), k2, -1, '0);
      check_all($sformatf("rnd%0d", t));
    end

    // Second start mid-expansion is ignored.
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = ~k1;
    model(k1);
    run("dup", k1, 9, k2);
    check_all("dup");

    // Reset mid-expansion aborts immediately.
    bus.key = {$urandom, $urandom, $urandom, $urandom}; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {127'b0, bus.busy}, 128'd0);
    chk("abort_kv", {127'b0, bus.key_valid}, 128'd0);
    chk("abort_rk", bus.round_key, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", {126'b0, bus.busy, bus.key_valid}, 128'd0);
    k1 = {$urandom, $urandom, $urandom, $urandom};
    model(k1);
    run("post", k1, -1, '0);
    check_all("post");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
